// File: rtl/fir_pkg.sv
// Shared definitions for the fir_mc filter bank and its parameter loader:
// loader/bus state encodings, control register address, error codes and control-word layout.
package fir_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWrCoef,
    StRdCoef,
    StWrCtrl,
    StRdCtrl,
    StFinish
  } loader_state_e;

  typedef enum logic {
    BusIdle,
    BusActive
  } bus_state_e;

  localparam logic [7:0] FIR_CTRL_ADDR = 8'hff;

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrTimeout  = 2'd1;
  localparam logic [1:0] ErrTaps     = 2'd2;
  localparam logic [1:0] ErrReadback = 2'd3;

  // Control word: {bypass, pcm_out_shift[3:0], tap_len[7:0], down_sample[7:0]}
  localparam int unsigned CtrlDownSampleLsb = 0;
  localparam int unsigned CtrlTapLenLsb     = 8;
  localparam int unsigned CtrlShiftLsb      = 16;
  localparam int unsigned CtrlBypassBit     = 20;
  localparam int unsigned CtrlWidth         = CtrlBypassBit + 1;

  typedef struct packed {
    logic                                       bypass;
    logic [CtrlBypassBit-CtrlShiftLsb-1:0]      pcm_out_shift;
    logic [CtrlShiftLsb-CtrlTapLenLsb-1:0]      tap_len;
    logic [CtrlTapLenLsb-CtrlDownSampleLsb-1:0] down_sample;
  } fir_ctrl_t;

endpackage

// File: rtl/reg_bus_master.sv
// Single-access register-bus initiator: registered strobe/address/data held until the
// responder's reg_ready, or dropped after TIMEOUT strobe cycles.
module reg_bus_master
  import fir_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_2,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rnw,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        timeout,
  output logic [7:0]  reg_addr,
  output logic        reg_rd,
  output logic        reg_wr,
  input  logic        reg_ready,
  output logic [31:0] reg_writedata,
  input  logic [31:0] reg_readdata
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  bus_state_e  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        active;

  // wait_q counts strobe cycles including the current one
  assign active  = (state_q == BusActive);
  assign ack     = active & reg_ready;
  assign timeout = active & ~reg_ready & (wait_q == TimeoutCnt);
  assign rdata   = reg_readdata;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      BusIdle: begin
        if (req) begin
          state_d = BusActive;
          wait_d  = 8'd1;
          addr_d  = addr;
          wdata_d = wdata;
          rd_d    = rnw;
          wr_d    = ~rnw;
        end
      end
      BusActive: begin
        if (ack || timeout) begin
          state_d = BusIdle;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = BusIdle;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      state_q <= BusIdle;
      wait_q  <= 8'd0;
      addr_q  <= 8'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign reg_addr      = addr_q;
  assign reg_writedata = wdata_q;
  assign reg_rd        = rd_q;
  assign reg_wr        = wr_q;

endmodule

// File: rtl/fir_param_loader.sv
// Programs one fir_mc bank: streams coefficients to addresses 0.. then writes the control word
// to 0xff. Define FIR_LOADER_READBACK_EN to verify every write with a readback.
module fir_param_loader
  import fir_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned MAX_TAPS = 254
) (
  input  logic                 clk_2,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [CtrlWidth-1:0] cfg_word,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  input  logic [31:0]          coef_data,
  input  logic                 coef_last,
  output logic [7:0]           reg_addr,
  output logic                 reg_rd,
  output logic                 reg_wr,
  input  logic                 reg_ready,
  output logic [31:0]          reg_writedata,
  input  logic [31:0]          reg_readdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [7:0]           coef_count
);

  localparam logic [7:0] MaxTapsCnt = 8'(MAX_TAPS);

  loader_state_e state_q, state_d;
  fir_ctrl_t     cfg_q;
  logic [31:0]   coef_q;
  logic          last_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic [7:0]    count_q;  // written-coefficient count, doubles as the parameter address
  logic          coef_done;

  logic          bus_req, bus_rnw, bus_ack, bus_timeout;
  logic [7:0]    bus_addr;
  logic [31:0]   bus_wdata, bus_rdata;

`ifdef FIR_LOADER_READBACK_EN
  logic rb_bad;
  assign rb_bad    = (state_q == StRdCtrl) ? (bus_rdata[CtrlWidth-1:0] != cfg_q)
                                           : (bus_rdata != coef_q);
  assign coef_done = (state_q == StRdCoef) && bus_ack && !rb_bad;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus_rdata;
  assign coef_done    = (state_q == StWrCoef) && bus_ack;
`endif

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_start) state_d = StFetch;
      StFetch: begin
        if (coef_valid) state_d = (count_q == MaxTapsCnt) ? StFinish : StWrCoef;
      end
      StWrCoef: begin
        if (bus_timeout) begin
          state_d = StFinish;
        end else if (bus_ack) begin
`ifdef FIR_LOADER_READBACK_EN
          state_d = StRdCoef;
`else
          state_d = last_q ? StWrCtrl : StFetch;
`endif
        end
      end
`ifdef FIR_LOADER_READBACK_EN
      StRdCoef: begin
        if (bus_timeout || (bus_ack && rb_bad)) state_d = StFinish;
        else if (bus_ack)                       state_d = last_q ? StWrCtrl : StFetch;
      end
      StWrCtrl: begin
        if (bus_timeout)  state_d = StFinish;
        else if (bus_ack) state_d = StRdCtrl;
      end
      StRdCtrl: if (bus_timeout || bus_ack) state_d = StFinish;
`else
      StWrCtrl: if (bus_timeout || bus_ack) state_d = StFinish;
`endif
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_req    = 1'b0;
    bus_rnw    = 1'b0;
    bus_addr   = count_q;
    bus_wdata  = coef_q;
    coef_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      StIdle:   busy = 1'b0;
      StFetch:  coef_ready = 1'b1;
      StWrCoef: bus_req = 1'b1;
      StRdCoef: begin
        bus_req = 1'b1;
        bus_rnw = 1'b1;
      end
      StWrCtrl: begin
        bus_req   = 1'b1;
        bus_addr  = FIR_CTRL_ADDR;
        bus_wdata = {{(32-CtrlWidth){1'b0}}, cfg_q};
      end
      StRdCtrl: begin
        bus_req  = 1'b1;
        bus_rnw  = 1'b1;
        bus_addr = FIR_CTRL_ADDR;
      end
      StFinish: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      coef_q     <= 32'd0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
      count_q    <= 8'd0;
    end else begin
      if (state_q == StIdle && cfg_start) begin
        cfg_q      <= cfg_word;
        err_q      <= 1'b0;
        err_code_q <= ErrNone;
        count_q    <= 8'd0;
      end
      if (state_q == StFetch && coef_valid) begin
        if (count_q == MaxTapsCnt) begin
          err_q      <= 1'b1;
          err_code_q <= ErrTaps;
        end else begin
          coef_q <= coef_data;
          last_q <= coef_last;
        end
      end
      if (bus_timeout) begin
        err_q      <= 1'b1;
        err_code_q <= ErrTimeout;
      end
`ifdef FIR_LOADER_READBACK_EN
      if (bus_ack && bus_rnw && rb_bad) begin
        err_q      <= 1'b1;
        err_code_q <= ErrReadback;
      end
`endif
      if (coef_done) count_q <= count_q + 8'd1;
    end
  end

  assign err        = err_q;
  assign err_code   = err_code_q;
  assign coef_count = count_q;

  reg_bus_master #(
    .TIMEOUT(TIMEOUT)
  ) u_bus (
    .clk_2         (clk_2),
    .rst_n         (rst_n),
    .req           (bus_req),
    .rnw           (bus_rnw),
    .addr          (bus_addr),
    .wdata         (bus_wdata),
    .ack           (bus_ack),
    .rdata         (bus_rdata),
    .timeout       (bus_timeout),
    .reg_addr      (reg_addr),
    .reg_rd        (reg_rd),
    .reg_wr        (reg_wr),
    .reg_ready     (reg_ready),
    .reg_writedata (reg_writedata),
    .reg_readdata  (reg_readdata)
  );

endmodule

// File: tb/tb_fir_param_loader.sv
// Scoreboard bench for fir_param_loader: a toggle-ack responder model, expected register writes
// and end-of-load status queued by the stimulus, popped and compared by a monitor.
module tb_fir_param_loader;

  logic        clk_2 = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [20:0] cfg_word;
  logic        coef_valid;
  logic        coef_ready;
  logic [31:0] coef_data;
  logic        coef_last;
  logic [7:0]  reg_addr;
  logic        reg_rd;
  logic        reg_wr;
  logic        reg_ready = 1'b0;
  logic [31:0] reg_writedata;
  logic [31:0] reg_readdata = 32'd0;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  coef_count;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_wr_q[$];   // {addr, data}
  logic [10:0] exp_end_q[$];  // {err, err_code, coef_count}
  int done_seen = 0;
  int last_len = 0;
  int cur_len = 0;
  int resp_delay = 0;
  bit no_ack = 1'b0;
  bit corrupt2 = 1'b0;
  int wait_cnt = 0;
  logic [31:0] mem [256];

  always #5 clk_2 = ~clk_2;

  fir_param_loader #(
    .TIMEOUT  (16),
    .MAX_TAPS (254)
  ) dut (
    .clk_2         (clk_2),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_word      (cfg_word),
    .coef_valid    (coef_valid),
    .coef_ready    (coef_ready),
    .coef_data     (coef_data),
    .coef_last     (coef_last),
    .reg_addr      (reg_addr),
    .reg_rd        (reg_rd),
    .reg_wr        (reg_wr),
    .reg_ready     (reg_ready),
    .reg_writedata (reg_writedata),
    .reg_readdata  (reg_readdata),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_code      (err_code),
    .coef_count    (coef_count)
  );

  // Responder: raises ready resp_delay cycles after seeing the strobe, drops it the next edge.
  always @(posedge clk_2) begin
    if (!rst_n) begin
      reg_ready <= 1'b0;
      wait_cnt  <= 0;
    end else if (reg_ready) begin
      reg_ready <= 1'b0;
    end else if ((reg_wr || reg_rd) && !no_ack) begin
      if (wait_cnt >= resp_delay) begin
        reg_ready <= 1'b1;
        wait_cnt  <= 0;
        if (reg_wr) mem[reg_addr] <= reg_writedata;
        else reg_readdata <= (corrupt2 && reg_addr == 8'd2) ? ~mem[reg_addr] : mem[reg_addr];
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic        prev_ready;
    logic [39:0] ew;
    logic [10:0] ee;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk_2);
      if (prev_ready) check("strobe_drop", {reg_rd, reg_wr}, 2'b00);
      if (reg_rd || reg_wr) check("rd_wr_excl", reg_rd & reg_wr, 1'b0);
      if (reg_wr && reg_ready) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%0h data=%0h expected none", reg_addr,
                   reg_writedata);
        end else begin
          ew = exp_wr_q.pop_front();
          check("wr_addr", reg_addr, ew[39:32]);
          check("wr_data", reg_writedata, ew[31:0]);
        end
      end
      if (done) begin
        done_seen++;
        if (exp_end_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done err_code=%0d expected no done", err_code);
        end else begin
          ee = exp_end_q.pop_front();
          check("end_err", err, ee[10]);
          check("end_err_code", err_code, ee[9:8]);
          check("end_coef_count", coef_count, ee[7:0]);
          check("end_busy", busy, 1'b0);
        end
      end
      if (reg_rd || reg_wr) begin
        cur_len++;
      end else if (cur_len != 0) begin
        last_len = cur_len;
        cur_len  = 0;
      end
      prev_ready = reg_ready;
    end
  end

  task automatic start_load(input logic [20:0] w);
    @(posedge clk_2);
    #1;
    cfg_word  = w;
    cfg_start = 1'b1;
    @(posedge clk_2);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_coef(input logic [31:0] d, input logic l);
    int n;
    n          = 0;
    coef_valid = 1'b1;
    coef_data  = d;
    coef_last  = l;
    @(negedge clk_2);
    while (!coef_ready && n < 500) begin
      n++;
      @(negedge clk_2);
    end
    if (!coef_ready) begin
      checks++;
      errors++;
      $display("FAIL coef_handshake data=%0h ready=0 expected 1", d);
    end
    @(posedge clk_2);
    #1;
    coef_valid = 1'b0;
    coef_last  = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_seen == base && n < 5000) begin
      @(negedge clk_2);
      n++;
    end
    repeat (5) @(negedge clk_2);
    check("done_once", done_seen, base + 1);
  endtask

  task automatic run_basic(input int dly, input int exp_len);
    int base;
    resp_delay = dly;
    base = done_seen;
    for (int i = 0; i < 4; i++) exp_wr_q.push_back({8'(i), 32'h11 * (i + 1)});
    exp_wr_q.push_back({8'hff, 32'h0009_0401});
    exp_end_q.push_back({1'b0, 2'd0, 8'd4});
    start_load(21'h09_0401);
    for (int i = 0; i < 4; i++) send_coef(32'h11 * (i + 1), i == 3);
    wait_done(base);
    check("basic_strobe_len", last_len, exp_len);
    check("basic_mem3", mem[3], 32'h44);
    check("basic_mem_ctrl", mem[255], 32'h0009_0401);
    check("basic_queue", exp_wr_q.size(), 0);
  endtask

  initial begin
    int base;
    rst_n      = 1'b0;
    cfg_start  = 1'b0;
    cfg_word   = '0;
    coef_valid = 1'b0;
    coef_data  = '0;
    coef_last  = 1'b0;
    repeat (3) @(posedge clk_2);
    @(negedge clk_2);
    check("reset_outputs", {busy, done, err, err_code, coef_count, reg_addr, reg_rd, reg_wr,
                            reg_writedata, coef_ready}, '0);
    @(posedge clk_2);
    #1 rst_n = 1'b1;

    run_basic(0, 2);

    // responder never acks: strobe held TIMEOUT cycles, then error end
    no_ack = 1'b1;
    base = done_seen;
    exp_end_q.push_back({1'b1, 2'd1, 8'd0});
    start_load(21'h00_0101);
    send_coef(32'h55, 1'b1);
    wait_done(base);
    check("timeout_strobe_len", last_len, 16);
    check("timeout_err_sticky", {err, err_code}, 3'b101);
    no_ack = 1'b0;

    run_basic(5, 7);

    // 255 coefficients, none last: 254 written, control never written
    resp_delay = 0;
    base = done_seen;
    for (int i = 0; i < 254; i++) exp_wr_q.push_back({8'(i), 32'h1000 + i});
    exp_end_q.push_back({1'b1, 2'd2, 8'd254});
    start_load(21'h10_fe00);
    for (int i = 0; i < 255; i++) send_coef(32'h1000 + i, 1'b0);
    wait_done(base);
    check("taps_queue", exp_wr_q.size(), 0);

`ifdef FIR_LOADER_READBACK_EN
    corrupt2 = 1'b1;
    base = done_seen;
    for (int i = 0; i < 3; i++) exp_wr_q.push_back({8'(i), 32'ha0 + i});
    exp_end_q.push_back({1'b1, 2'd3, 8'd2});
    start_load(21'h09_0401);
    for (int i = 0; i < 3; i++) send_coef(32'ha0 + i, 1'b0);
    wait_done(base);
    corrupt2 = 1'b0;
`endif

    // reset during the second coefficient write, then a fresh load from address 0
    resp_delay = 5;
    exp_wr_q.push_back({8'd0, 32'h11});
    start_load(21'h09_0401);
    send_coef(32'h11, 1'b0);
    send_coef(32'h22, 1'b0);
    begin
      int n;
      n = 0;
      while (!(reg_wr && reg_addr == 8'd1) && n < 100) begin
        @(negedge clk_2);
        n++;
      end
    end
    check("rst_second_strobe_seen", {reg_wr, reg_addr}, {1'b1, 8'd1});
    rst_n = 1'b0;
    @(negedge clk_2);
    check("rst_strobe_low", {reg_rd, reg_wr}, 2'b00);
    check("rst_busy_low", busy, 1'b0);
    @(posedge clk_2);
    #1 rst_n = 1'b1;
    base = done_seen;
    exp_wr_q.push_back({8'd0, 32'hab});
    exp_wr_q.push_back({8'hff, 32'h0015_0102});
    exp_end_q.push_back({1'b0, 2'd0, 8'd1});
    start_load(21'h15_0102);
    send_coef(32'hab, 1'b1);
    wait_done(base);

    check("final_wr_queue", exp_wr_q.size(), 0);
    check("final_end_queue", exp_end_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time=%0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
